ir_code_transmitter: RTL and testbench
======================================

IR_CODE_TRANSMITTER -- requirements
Module: ir_code_transmitter

Interface
REQ-001 The block SHALL have parameter UNIT_CYCLES, default 41766, meaning clock cycles per 562.5 us protocol unit at 74.25 MHz.
REQ-002 The block SHALL have parameter CARRIER_HALF, default 977, meaning clock cycles per half period of the ~38 kHz carrier.
REQ-003 The block SHALL have parameter GAP_UNITS, default 70, meaning the number of idle units enforced after each stop mark.
REQ-004 The block SHALL have port clk_pixel_in, input, 1, the sole clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_in, input, 1, a synchronous, active-low reset (0 = reset).
REQ-006 The block SHALL have port code_in, input, 32, the code to transmit, e.g. 32'hDEADBEEF (block) or 32'h20FACADE (lunge).
REQ-007 The block SHALL have port code_in_valid, input, 1, which requests transmission of code_in.
REQ-008 The block SHALL have port ready_out, output, 1, which is high when a request will be accepted.
REQ-009 The block SHALL have port ir_out, output, 1, the carrier-modulated drive to the IR LED.
REQ-010 The block SHALL have port envelope_out, output, 1, the unmodulated mark envelope (1 = mark).
REQ-011 The block SHALL have port busy_out, output, 1, which is high from acceptance through the end of the gap.
REQ-012 The block SHALL have port done_out, output, 1, a one-cycle pulse on the last gap cycle.

Function
REQ-013 The block SHALL accept a request on any cycle where code_in_valid && ready_out, registering code_in internally; later code_in changes SHALL NOT affect the frame.
REQ-014 ready_out SHALL equal !busy_out; code_in_valid while busy SHALL be ignored and not queued.
REQ-015 The block SHALL use FSM states IDLE -> LEAD_MARK (16 units) -> LEAD_SPACE (8 units) -> BIT_MARK (1 unit) -> BIT_SPACE (1 unit for bit 0, 3 units for bit 1) -> back to BIT_MARK until 32 bits are sent -> STOP_MARK (1 unit) -> GAP (GAP_UNITS) -> IDLE.
REQ-016 The block SHALL send bits MSB first (code bit 31 first) using a 5-bit bit index; after bit 0's space it SHALL move to STOP_MARK.
REQ-017 The block SHALL enter LEAD_MARK on the cycle after acceptance; envelope_out SHALL go high on that cycle.
REQ-018 The unit counter SHALL count 0..UNIT_CYCLES-1 and wrap; a per-state unit count SHALL set each state's duration exactly, with no extra cycles at state boundaries.
REQ-019 envelope_out SHALL be 1 exactly in LEAD_MARK, BIT_MARK and STOP_MARK, and 0 elsewhere.
REQ-020 The carrier SHALL restart at level 1 on the first cycle of every mark state and toggle every CARRIER_HALF cycles; ir_out SHALL equal envelope_out AND carrier, registered with no glitches.
REQ-021 busy_out SHALL be high in every state except IDLE.
REQ-022 done_out SHALL pulse on the final GAP cycle; IDLE follows on the next cycle, and a new request can be accepted that cycle.
REQ-023 Total frame length SHALL be (24 + 2*zeros + 4*ones + 1 + GAP_UNITS) * UNIT_CYCLES cycles.

Reset
REQ-024 When rst_in = 0 at a clock edge, the FSM SHALL go to IDLE and all counters SHALL clear; ir_out, envelope_out, busy_out and done_out SHALL be 0, and ready_out 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame, force ir_out = 0 on the next cycle, and discard the code; no done_out pulse SHALL occur.

Verification (UNIT_CYCLES=4, CARRIER_HALF=1, GAP_UNITS=2)
REQ-026 Accept 32'hDEADBEEF at cycle T -> envelope_out high for cycles T+1..T+64, low T+65..T+96; first data mark at T+97; done_out pulse at T+556; busy_out low at T+557.
REQ-027 During the leader mark -> ir_out = 1,0,1,0,... starting at T+1; ir_out = 0 whenever envelope_out = 0.
REQ-028 Send 32'h20FACADE -> decoded space lengths give 0x20FACADE (4-cycle space = 0, 12-cycle space = 1), MSB first.
REQ-029 Pulse code_in_valid with 32'h20FACADE at T+200 during a 32'hDEADBEEF frame -> ignored; envelope timing is unchanged and no second frame follows.
REQ-030 Drive rst_in = 0 at T+150 -> ir_out, envelope_out and busy_out are 0 and ready_out is 1 from T+151; no done_out pulse.
REQ-031 Hold code_in_valid high continuously -> frames run back-to-back, each new one accepted on the cycle after done_out.

Source files
------------

// File: rtl/ir_code_transmitter.sv
// NEC-style IR frame transmitter: leader, 32 pulse-distance bits MSB first, stop mark, idle gap.
// The mark envelope gates a free-running carrier that restarts high at every mark.
module ir_code_transmitter #(
  parameter int UNIT_CYCLES  = 41766,
  parameter int CARRIER_HALF = 977,
  parameter int GAP_UNITS    = 70
) (
  input  logic        clk_pixel_in,
  input  logic        rst_in,
  input  logic [31:0] code_in,
  input  logic        code_in_valid,
  output logic        ready_out,
  output logic        ir_out,
  output logic        envelope_out,
  output logic        busy_out,
  output logic        done_out
);

  localparam int MAX_UNITS = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int UC_W      = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int UI_W      = (MAX_UNITS > 1) ? $clog2(MAX_UNITS) : 1;
  localparam int CH_W      = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
  } state_t;

  state_t          state_q, state_n;
  logic [UC_W-1:0] unit_cnt_q, unit_cnt_n;
  logic [UI_W-1:0] unit_idx_q, unit_idx_n, last_idx;
  logic [4:0]      bit_idx_q, bit_idx_n;
  logic [31:0]     code_q;
  logic [CH_W-1:0] car_cnt_q, car_cnt_n;
  logic            carrier_q, carrier_n;
  logic            accept, unit_last, state_last;

  function automatic logic is_mark(input state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

  // State and counter registers; ir_out is registered from next-cycle values so it never glitches
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      unit_cnt_q <= '0;
      unit_idx_q <= '0;
      bit_idx_q  <= '0;
      car_cnt_q  <= '0;
      carrier_q  <= 1'b0;
      ir_out     <= 1'b0;
    end else begin
      state_q    <= state_n;
      unit_cnt_q <= unit_cnt_n;
      unit_idx_q <= unit_idx_n;
      bit_idx_q  <= bit_idx_n;
      car_cnt_q  <= car_cnt_n;
      carrier_q  <= carrier_n;
      ir_out     <= is_mark(state_n) & carrier_n;
    end
  end

  // Code is captured only at acceptance, so later code_in changes cannot leak into the frame
  always_ff @(posedge clk_pixel_in) begin
    if (accept) code_q <= code_in;
  end

  // Next-state and counter logic
  always_comb begin
    accept     = code_in_valid && (state_q == IDLE);
    unit_last  = (unit_cnt_q == UC_W'(UNIT_CYCLES - 1));
    case (state_q)
      LEAD_MARK:  last_idx = UI_W'(15);
      LEAD_SPACE: last_idx = UI_W'(7);
      BIT_SPACE:  last_idx = code_q[bit_idx_q] ? UI_W'(2) : UI_W'(0);
      GAP:        last_idx = UI_W'(GAP_UNITS - 1);
      default:    last_idx = '0;
    endcase
    state_last = unit_last && (unit_idx_q == last_idx);

    state_n    = state_q;
    unit_cnt_n = unit_cnt_q;
    unit_idx_n = unit_idx_q;
    bit_idx_n  = bit_idx_q;

    if (state_q == IDLE) begin
      unit_cnt_n = '0;
      unit_idx_n = '0;
      if (accept) begin
        state_n   = LEAD_MARK;
        bit_idx_n = 5'd31;
      end
    end else begin
      unit_cnt_n = unit_last ? '0 : unit_cnt_q + UC_W'(1);
      if (unit_last) unit_idx_n = state_last ? '0 : unit_idx_q + UI_W'(1);
      if (state_last) begin
        case (state_q)
          LEAD_MARK:  state_n = LEAD_SPACE;
          LEAD_SPACE: state_n = BIT_MARK;
          BIT_MARK:   state_n = BIT_SPACE;
          BIT_SPACE: begin
            state_n   = (bit_idx_q == 5'd0) ? STOP_MARK : BIT_MARK;
            bit_idx_n = bit_idx_q - 5'd1;
          end
          STOP_MARK:  state_n = GAP;
          GAP:        state_n = IDLE;
          default:    state_n = IDLE;
        endcase
      end
    end

    // Every mark state is entered from a different state, so a state change marks its first cycle
    if (!is_mark(state_n)) begin
      carrier_n = 1'b0;
      car_cnt_n = '0;
    end else if (state_n != state_q) begin
      carrier_n = 1'b1;
      car_cnt_n = '0;
    end else if (car_cnt_q == CH_W'(CARRIER_HALF - 1)) begin
      carrier_n = ~carrier_q;
      car_cnt_n = '0;
    end else begin
      carrier_n = carrier_q;
      car_cnt_n = car_cnt_q + CH_W'(1);
    end
  end

  always_comb begin
    envelope_out = is_mark(state_q);
    busy_out     = (state_q != IDLE);
    ready_out    = (state_q == IDLE);
    done_out     = (state_q == GAP) && state_last;
  end

endmodule

// File: tb/tb_ir_code_transmitter.sv
// Directed bench for ir_code_transmitter with short units (4 cycles/unit, 1-cycle carrier half, 2 gap units).
module tb_ir_code_transmitter;

  logic        clk_pixel_in;
  logic        rst_in;
  logic [31:0] code_in;
  logic        code_in_valid;
  logic        ready_out, ir_out, envelope_out, busy_out, done_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic env_a   [0:1199];
  logic ir_a    [0:1199];
  logic done_a  [0:1199];
  logic busy_a  [0:1199];
  logic ready_a [0:1199];

  ir_code_transmitter #(
    .UNIT_CYCLES  (4),
    .CARRIER_HALF (1),
    .GAP_UNITS    (2)
  ) dut (
    .clk_pixel_in  (clk_pixel_in),
    .rst_in        (rst_in),
    .code_in       (code_in),
    .code_in_valid (code_in_valid),
    .ready_out     (ready_out),
    .ir_out        (ir_out),
    .envelope_out  (envelope_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  initial begin
    clk_pixel_in = 1'b0;
    forever #5 clk_pixel_in = ~clk_pixel_in;
  end

  task automatic step();
    @(posedge clk_pixel_in);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record outputs for cycles T+1..T+n after an acceptance cycle T, optionally injecting a request or reset.
  task automatic capture(input int n, input int inj_cyc, input logic [31:0] inj_code,
                         input int rst_cyc, input logic hold);
    for (int c = 1; c <= n; c++) begin
      step();
      env_a[c]   = envelope_out;
      ir_a[c]    = ir_out;
      done_a[c]  = done_out;
      busy_a[c]  = busy_out;
      ready_a[c] = ready_out;
      code_in_valid = hold;
      rst_in = 1'b1;
      if (!hold) code_in = 32'h0;
      if (c == inj_cyc) begin
        code_in_valid = 1'b1;
        code_in = inj_code;
      end
      if (c == rst_cyc) rst_in = 1'b0;
    end
  endtask

  function automatic int sum_env(input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) s += int'(env_a[i]);
    return s;
  endfunction

  function automatic int sum_ir(input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) s += int'(ir_a[i]);
    return s;
  endfunction

  function automatic int sum_done(input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) s += int'(done_a[i]);
    return s;
  endfunction

  function automatic int sum_busy(input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) s += int'(busy_a[i]);
    return s;
  endfunction

  function automatic int ir_without_env(input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) if (ir_a[i] && !env_a[i]) s++;
    return s;
  endfunction

  // Space after each data mark: 4 cycles -> 0, 12 cycles -> 1; first data mark at T+97
  function automatic logic [31:0] decode_frame();
    int pos = 97;
    int len;
    logic [31:0] d = '0;
    for (int b = 0; b < 32; b++) begin
      len = 0;
      while (pos < 1199 && env_a[pos] == 1'b1) pos++;
      while (pos < 1199 && env_a[pos] == 1'b0 && len < 40) begin
        len++;
        pos++;
      end
      d = {d[30:0], 1'(len > 8)};
    end
    return d;
  endfunction

  initial begin
    rst_in = 1'b0;
    code_in = 32'h0;
    code_in_valid = 1'b0;
    step(); step(); step();
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_env", 32'(envelope_out), 32'd0);
    check("rst_ir", 32'(ir_out), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    rst_in = 1'b1;
    step();
    check("idle_ready", 32'(ready_out), 32'd1);

    // Frame 1: DEADBEEF, code_in cleared after accept, ignored request at T+200
    code_in = 32'hDEADBEEF;
    code_in_valid = 1'b1;
    capture(620, 200, 32'h20FACADE, -1, 1'b0);
    check("f1_env_t1", 32'(env_a[1]), 32'd1);
    check("f1_env_t64", 32'(env_a[64]), 32'd1);
    check("f1_env_t65", 32'(env_a[65]), 32'd0);
    check("f1_env_t96", 32'(env_a[96]), 32'd0);
    check("f1_env_t97", 32'(env_a[97]), 32'd1);
    check("f1_lead_ones", 32'(sum_env(1, 64)), 32'd64);
    check("f1_lead_space", 32'(sum_env(65, 96)), 32'd0);
    check("f1_ir_t1", 32'(ir_a[1]), 32'd1);
    check("f1_ir_t2", 32'(ir_a[2]), 32'd0);
    check("f1_ir_t3", 32'(ir_a[3]), 32'd1);
    check("f1_ir_lead_ones", 32'(sum_ir(1, 64)), 32'd32);
    check("f1_ir_gated", 32'(ir_without_env(1, 620)), 32'd0);
    check("f1_decode", decode_frame(), 32'hDEADBEEF);
    check("f1_done_t555", 32'(done_a[555]), 32'd0);
    check("f1_done_t556", 32'(done_a[556]), 32'd1);
    check("f1_done_count", 32'(sum_done(1, 620)), 32'd1);
    check("f1_busy_t556", 32'(busy_a[556]), 32'd1);
    check("f1_busy_t557", 32'(busy_a[557]), 32'd0);
    check("f1_ready_t557", 32'(ready_a[557]), 32'd1);
    check("f1_no_second", 32'(sum_busy(557, 620)), 32'd0);

    // Frame 2: 20FACADE, 17 ones and 15 zeros -> 125 units = 500 cycles
    code_in = 32'h20FACADE;
    code_in_valid = 1'b1;
    capture(520, -1, 32'h0, -1, 1'b0);
    check("f2_decode", decode_frame(), 32'h20FACADE);
    check("f2_done_t500", 32'(done_a[500]), 32'd1);
    check("f2_done_count", 32'(sum_done(1, 520)), 32'd1);
    check("f2_busy_t500", 32'(busy_a[500]), 32'd1);
    check("f2_busy_t501", 32'(busy_a[501]), 32'd0);
    check("f2_ir_gated", 32'(ir_without_env(1, 520)), 32'd0);

    // Frame 3: reset driven at T+150 aborts the frame
    code_in = 32'hDEADBEEF;
    code_in_valid = 1'b1;
    capture(600, -1, 32'h0, 150, 1'b0);
    check("f3_busy_t150", 32'(busy_a[150]), 32'd1);
    check("f3_ready_t151", 32'(ready_a[151]), 32'd1);
    check("f3_ir_after", 32'(sum_ir(151, 600)), 32'd0);
    check("f3_env_after", 32'(sum_env(151, 600)), 32'd0);
    check("f3_busy_after", 32'(sum_busy(151, 600)), 32'd0);
    check("f3_no_done", 32'(sum_done(1, 600)), 32'd0);

    // Frame 4: valid held high -> back-to-back frames
    code_in = 32'hDEADBEEF;
    code_in_valid = 1'b1;
    capture(1150, -1, 32'h0, -1, 1'b1);
    check("f4_done_t556", 32'(done_a[556]), 32'd1);
    check("f4_ready_t557", 32'(ready_a[557]), 32'd1);
    check("f4_env_t557", 32'(env_a[557]), 32'd0);
    check("f4_env_t558", 32'(env_a[558]), 32'd1);
    check("f4_busy_t558", 32'(busy_a[558]), 32'd1);
    check("f4_done_t1113", 32'(done_a[1113]), 32'd1);
    check("f4_env_t1115", 32'(env_a[1115]), 32'd1);
    check("f4_done_count", 32'(sum_done(1, 1150)), 32'd2);
    code_in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
